// File: rtl/rv32im_muldiv_sequencer_pkg.sv
// rv32im_pkg: shared definitions for the RV32IM multiply/divide sequencer.
//   state_e       FSM state encoding
//   SN_*          operand signedness encodings ([1]=rs1 signed, [0]=rs2 signed)
//   DIV0_QUOT     quotient returned for a divide by zero
//   OVF_QUOT      quotient returned for the signed overflow case
//   ITER_CNT      iterations per multi-cycle divide/multiply
package rv32im_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] SN_SS = 2'b11;
  localparam logic [1:0] SN_SU = 2'b10;
  localparam logic [1:0] SN_UU = 2'b00;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

  localparam int ITER_CNT = 32;

endpackage

// File: rtl/rv32im_muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the M-extension
// sequencer.
//   master: execute stage (drives request, flush; observes status/result)
//   slave : sequencer
//   start/mul_en/div_en  request valid and operation class
//   sn                   [1]=rs1 signed, [0]=rs2 signed
//   m_sel                bit 0: mul high word / div remainder
//   rs1_data/rs2_data    operands
//   flush                abort in-flight operation
//   busy/stall/done      status; result is the registered answer
interface rv32im_muldiv_sequencer_if;
  logic        start;
  logic        mul_en;
  logic        div_en;
  logic [1:0]  sn;
  logic [1:0]  m_sel;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, mul_en, div_en, sn, m_sel, rs1_data, rs2_data, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, mul_en, div_en, sn, m_sel, rs1_data, rs2_data, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/rv32im_muldiv_sequencer_div_step.sv
// rv32im_div_step: one combinational radix-2 restoring division step.
//   rem_in/quo_in  partial remainder and remaining dividend bits
//   dvsr           divisor (unsigned magnitude)
//   rem_out        new partial remainder
//   quo_out        dividend shifted left with the new quotient bit in bit 0
module rv32im_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);
  logic [W:0] shifted;
  logic       q_bit;

  assign shifted = {rem_in, quo_in[W-1]};
  assign q_bit   = (shifted >= {1'b0, dvsr});
  // When q_bit is set the true difference is below dvsr, so W bits suffice.
  assign rem_out = q_bit ? (shifted[W-1:0] - dvsr) : shifted[W-1:0];
  assign quo_out = {quo_in[W-2:0], q_bit};
endmodule

// File: rtl/rv32im_muldiv_sequencer.sv
// rv32im_muldiv_sequencer: multi-cycle RV32IM MUL/DIV/REM unit.
// Iterative restoring divider, plus either an iterative shift-add multiplier
// (default) or a single-cycle multiplier when RV32IM_FAST_MUL_EN is defined.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   rv32im_muldiv_sequencer_if.slave (request, flush, busy, stall,
//         done pulse, registered result)
//
// state | meaning
// IDLE  | waiting for a request
// MUL   | shift-add multiply iterations (unused with fast multiply)
// DIV   | restoring divide iterations
// FIX   | sign correction and word select, result registered
// DONE  | one-cycle done pulse; may accept the next request
module rv32im_muldiv_sequencer
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  rv32im_muldiv_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_MUL    = ST_MUL;
  localparam logic [2:0] S_DIV    = ST_DIV;
  localparam logic [2:0] S_FIX    = ST_FIX;
  localparam logic [2:0] S_DONE   = ST_DONE;
  localparam logic [5:0] CNT_LAST = 6'(ITER_CNT - 1);

  logic [2:0]        state_q, state_d;
  logic [5:0]        cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvsr_q, result_q;
  logic              op_mul_q, hi_sel_q, res_neg_q, busy_q, done_q;

  logic              idle_or_done, accept, a_neg, b_neg;
  logic              div_zero, div_ovf, div_special, short_op, run_state;
  logic [XLEN-1:0]   a_abs, b_abs, special_res, fast_res;
  logic [XLEN-1:0]   step_rem, step_quo, mul_hi_next, mul_lo_next, fix_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] fix_raw, fix_val;
  logic              unused_m_sel;

  assign unused_m_sel = bus.m_sel[1];

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept = bus.start && (bus.mul_en ^ bus.div_en) && !bus.flush && idle_or_done;

  assign a_neg = bus.sn[1] & bus.rs1_data[XLEN-1];
  assign b_neg = bus.sn[0] & bus.rs2_data[XLEN-1];
  assign a_abs = a_neg ? -bus.rs1_data : bus.rs1_data;
  assign b_abs = b_neg ? -bus.rs2_data : bus.rs2_data;

  assign div_zero    = (bus.rs2_data == '0);
  assign div_ovf     = (bus.sn == SN_SS) && (bus.rs1_data == OVF_QUOT) && (bus.rs2_data == '1);
  assign div_special = bus.div_en && (div_zero || div_ovf);
  // Zero divide wins when both apply (divisor 0 cannot be -1 anyway).
  assign special_res = div_zero ? (bus.m_sel[0] ? bus.rs1_data : DIV0_QUOT)
                                : (bus.m_sel[0] ? '0 : OVF_QUOT);

`ifdef RV32IM_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
  logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
  // Sign/zero extension to 64 bits gives the 33x33 signed product mod 2^64.
  assign fm_a     = {{XLEN{a_neg}}, bus.rs1_data};
  assign fm_b     = {{XLEN{b_neg}}, bus.rs2_data};
  assign fm_p     = fm_a * fm_b;
  assign fast_res = bus.m_sel[0] ? fm_p[2*XLEN-1:XLEN] : fm_p[XLEN-1:0];
`else
  localparam logic FAST_MUL = 1'b0;
  assign fast_res = '0;
`endif

  assign short_op = div_special || (bus.mul_en && FAST_MUL);

  rv32im_div_step #(.W(XLEN)) u_div_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .dvsr   (dvsr_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  // Shift-add: {rem_q, quo_q} is the 64-bit accumulator/multiplier pair,
  // dvsr_q holds the multiplicand.
  assign mul_sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvsr_q} : '0);
  assign mul_hi_next = mul_sum[XLEN:1];
  assign mul_lo_next = {mul_sum[0], quo_q[XLEN-1:1]};

  assign fix_raw = op_mul_q ? {rem_q, quo_q} : {{XLEN{1'b0}}, (hi_sel_q ? rem_q : quo_q)};
  assign fix_val = res_neg_q ? -fix_raw : fix_raw;
  assign fix_res = (op_mul_q && hi_sel_q) ? fix_val[2*XLEN-1:XLEN] : fix_val[XLEN-1:0];

  assign run_state  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign bus.stall  = run_state || (accept && !div_special);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (!accept)       state_d = S_IDLE;
          else if (short_op) state_d = S_DONE;
          else if (bus.mul_en) state_d = S_MUL;
          else               state_d = S_DIV;
        end
        S_MUL, S_DIV: if (cnt_q == CNT_LAST) state_d = S_FIX;
        S_FIX:        state_d = S_DONE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      op_mul_q  <= 1'b0;
      hi_sel_q  <= 1'b0;
      res_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
      done_q  <= (state_d == S_DONE);
      if (accept) begin
        op_mul_q  <= bus.mul_en;
        hi_sel_q  <= bus.m_sel[0];
        cnt_q     <= '0;
        // Remainder takes the dividend's sign; products/quotients the xor.
        res_neg_q <= (bus.div_en && bus.m_sel[0]) ? a_neg : (a_neg ^ b_neg);
        rem_q     <= '0;
        quo_q     <= bus.mul_en ? b_abs : a_abs;
        dvsr_q    <= bus.mul_en ? a_abs : b_abs;
        if (div_special)   result_q <= special_res;
        else if (short_op) result_q <= fast_res;
      end else if (!bus.flush) begin
        case (state_q)
          S_MUL: begin
            rem_q <= mul_hi_next;
            quo_q <= mul_lo_next;
            cnt_q <= cnt_q + 6'd1;
          end
          S_DIV: begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + 6'd1;
          end
          S_FIX:   result_q <= fix_res;
          default: begin end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rv32im_muldiv_sequencer.sv
// Bench for rv32im_muldiv_sequencer: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// flush / reset / back-to-back / illegal-request sequences.
module tb_rv32im_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  rv32im_muldiv_sequencer_if bus ();

  rv32im_muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef RV32IM_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  typedef struct {
    string       name;
    logic        mul;
    logic [1:0]  sn;
    logic        msel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: 64-bit products and SV division semantics.
  function automatic logic [31:0] ref_model(input logic mul, input logic [1:0] sn,
                                            input logic hi, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = sn[1] ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sn[0] ? longint'($signed(b)) : longint'({32'b0, b});
    if (mul) begin
      p = 64'(sa * sb);
      return hi ? p[63:32] : p[31:0];
    end
    if (b == 32'd0) return hi ? a : 32'hFFFF_FFFF;
    if (sn == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return hi ? 32'd0 : 32'h8000_0000;
    q = sa / sb;
    r = sa % sb;
    p = hi ? 64'(r) : 64'(q);
    return p[31:0];
  endfunction

  task automatic run_op(input logic mul, input logic [1:0] sn, input logic msel,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat,
                        output int st_n, output int bz_n);
    bus.start    = 1'b1;
    bus.mul_en   = mul;
    bus.div_en   = !mul;
    bus.sn       = sn;
    bus.m_sel    = {1'($urandom), msel};
    bus.rs1_data = a;
    bus.rs2_data = b;
    #1;
    st_n = int'(bus.stall);
    bz_n = 0;
    lat  = -1;
    res  = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      #1;
      if (bus.done) begin
        lat = cyc;
        res = bus.result;
        break;
      end
      st_n += int'(bus.stall);
      bz_n += int'(bus.busy);
    end
  endtask

  task automatic exec_check(input string name, input logic mul, input logic [1:0] sn,
                            input logic msel, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input int exp_lat, input bit chk_pulse);
    logic [31:0] res;
    int lat, st_n, bz_n, exp_st;
    exp_st = (!mul && exp_lat == 1) ? 0 : exp_lat;
    run_op(mul, sn, msel, a, b, res, lat, st_n, bz_n);
    check({name, ".result"}, res, exp_res);
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".stall_cycles"}, 32'(st_n), 32'(exp_st));
    check({name, ".busy_cycles"}, 32'(bz_n), 32'((exp_st == 0) ? 0 : exp_lat - 1));
    if (chk_pulse) begin
      @(negedge clk);
      #1;
      check({name, ".done_pulse_end"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_mul, r_msel;
    logic [1:0]  r_sn;
    logic [31:0] r_a, r_b;
    int          r_lat;
    bit          saw_done;

    vecs[0]  = '{"mul_ss_lo",      1'b1, 2'b11, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{"mulhu",          1'b1, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[2]  = '{"mulhsu",         1'b1, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[3]  = '{"mulh_min_min",   1'b1, 2'b11, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
    vecs[4]  = '{"mul_uu_lo",      1'b1, 2'b00, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT};
    vecs[5]  = '{"div_neg20_3",    1'b0, 2'b11, 1'b0, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, DIV_LAT};
    vecs[6]  = '{"rem_neg20_3",    1'b0, 2'b11, 1'b1, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, DIV_LAT};
    vecs[7]  = '{"divu_by0",       1'b0, 2'b00, 1'b0, 32'd100,       32'd0,         32'hFFFF_FFFF, 1};
    vecs[8]  = '{"remu_by0",       1'b0, 2'b00, 1'b1, 32'd100,       32'd0,         32'd100,       1};
    vecs[9]  = '{"div_ovf",        1'b0, 2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[10] = '{"rem_ovf",        1'b0, 2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[11] = '{"divu_9_2",       1'b0, 2'b00, 1'b0, 32'd9,         32'd2,         32'd4,         DIV_LAT};
    vecs[12] = '{"remu_max_16",    1'b0, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'd16,        32'd15,        DIV_LAT};

    bus.start = 1'b0; bus.mul_en = 1'b0; bus.div_en = 1'b0; bus.sn = 2'b00;
    bus.m_sel = 2'b00; bus.rs1_data = '0; bus.rs2_data = '0; bus.flush = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.busy",   32'(bus.busy),  32'd0);
    check("reset.stall",  32'(bus.stall), 32'd0);
    check("reset.done",   32'(bus.done),  32'd0);
    check("reset.result", bus.result,     32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      exec_check(vecs[i].name, vecs[i].mul, vecs[i].sn, vecs[i].msel,
                 vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);
    end

    for (int n = 0; n < 40; n++) begin
      r_mul  = 1'($urandom_range(0, 1));
      r_msel = 1'($urandom_range(0, 1));
      if (r_mul) begin
        case ($urandom_range(0, 2))
          0:       r_sn = 2'b11;
          1:       r_sn = 2'b10;
          default: r_sn = 2'b00;
        endcase
      end else begin
        r_sn = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      end
      case ($urandom_range(0, 7))
        0: begin r_a = $urandom; r_b = 32'd0; end
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: begin r_a = 32'($urandom_range(0, 50)); r_b = 32'($urandom_range(1, 9)); end
        3: begin r_a = -32'($urandom_range(1, 1000)); r_b = 32'($urandom_range(1, 40)); end
        default: begin r_a = $urandom; r_b = $urandom; end
      endcase
      if (r_mul) r_lat = MUL_LAT;
      else if (r_b == 32'd0 || (r_sn == 2'b11 && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF))
        r_lat = 1;
      else r_lat = DIV_LAT;
      @(negedge clk);
      exec_check($sformatf("rand%0d", n), r_mul, r_sn, r_msel, r_a, r_b,
                 ref_model(r_mul, r_sn, r_msel, r_a, r_b), r_lat, 1'b1);
    end

    // Flush in cycle 10 of a divide.
    @(negedge clk);
    exec_check("pre_flush_divu", 1'b0, 2'b00, 1'b0, 32'd1000, 32'd7, 32'd142, DIV_LAT, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.mul_en = 1'b0; bus.div_en = 1'b1; bus.sn = 2'b11;
    bus.m_sel = 2'b00; bus.rs1_data = 32'hFFFF_FFEC; bus.rs2_data = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush.busy_next",  32'(bus.busy),  32'd0);
    check("flush.stall_next", 32'(bus.stall), 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("flush.no_done", 32'(saw_done), 32'd0);
    check("flush.result_kept", bus.result, 32'd142);
    @(negedge clk);
    exec_check("divu_after_flush", 1'b0, 2'b00, 1'b0, 32'd9, 32'd2, 32'd4, DIV_LAT, 1'b1);

    // Asynchronous reset in cycle 5 of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.mul_en = 1'b0; bus.div_en = 1'b1; bus.sn = 2'b00;
    bus.m_sel = 2'b00; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.busy",   32'(bus.busy),  32'd0);
    check("rst_mid.stall",  32'(bus.stall), 32'd0);
    check("rst_mid.done",   32'(bus.done),  32'd0);
    check("rst_mid.result", bus.result,     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: second request accepted in the DONE cycle of the first.
    @(negedge clk);
    exec_check("b2b_first",  1'b0, 2'b00, 1'b0, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b0);
    exec_check("b2b_second", 1'b0, 2'b11, 1'b1, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, DIV_LAT, 1'b1);

    // Illegal request: both classes asserted.
    @(negedge clk);
    bus.start = 1'b1; bus.mul_en = 1'b1; bus.div_en = 1'b1; bus.sn = 2'b00;
    bus.m_sel = 2'b00; bus.rs1_data = 32'd5; bus.rs2_data = 32'd3;
    #1;
    check("illegal.stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.mul_en = 1'b0; bus.div_en = 1'b0;
    #1;
    check("illegal.busy", 32'(bus.busy), 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("illegal.no_activity", 32'(saw_done), 32'd0);
    check("illegal.result_kept", bus.result, 32'hFFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32im_muldiv_sequencer.md
# rv32im_muldiv_sequencer

Multi-cycle sequencer for the RV32IM M-extension. It accepts a decoded MUL/DIV/REM request (sign mode, result select, operands) from the execute stage and runs an iterative radix-2 restoring divider (and, optionally, an iterative shift-add multiplier). It stalls the pipeline while busy and returns a registered 32-bit result with a one-cycle done pulse. The block sits beside the RV32I ALU; the control path's `result_sel` chooses between the ALU output and this block's output.

## Interface

Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request valid; qualified by the decoder's M-extension decode
- `mul_en`  in  1  multiply class (MUL/MULH/MULHSU/MULHU)
- `div_en`  in  1  divide class (DIV/DIVU/REM/REMU)
- `sn`  in  2  [1]=rs1 signed, [0]=rs2 signed (11/10/00)
- `m_sel`  in  2  only bit 0 is used: mul 0=low word, 1=high word; div 0=quotient, 1=remainder
- `rs1_data`  in  32  dividend / multiplicand
- `rs2_data`  in  32  divisor / multiplier
- `flush`  in  1  abort the in-flight operation (branch/trap)
- `busy`  out  1  operation in progress
- `stall`  out  1  hold IF/ID/EX; combinational
- `done`  out  1  one-cycle pulse; `result` is valid
- `result`  out  32  final value; held until the next accepted start

## Operation

- States: IDLE, MUL, DIV, FIX, DONE.
- Reset values: state=IDLE; `busy`=0, `done`=0, `result`=0, `stall`=0, all iteration registers 0.
- Accept rule: `start` is accepted in IDLE or DONE when `mul_en` xor `div_en` = 1 and `flush`=0. Otherwise `start` is ignored. `mul_en`==`div_en` is an illegal request and causes no state change.
- On accept, latch `sn`, `m_sel[0]`, and the operand absolute values. Compute the result sign:
  - quotient/product sign = sign(rs1) xor sign(rs2) for the signed operands;
  - remainder sign = sign(rs1).
- Divide special cases resolve on accept and go directly to DONE:
  - divisor=0: quotient=0xFFFFFFFF, remainder=rs1;
  - signed overflow (0x80000000 / 0xFFFFFFFF, `sn`=11): quotient=0x80000000, remainder=0.
- DIV: 32 iterations on a 6-bit counter from 0 to 31. Each iteration shifts the remainder:dividend pair left by 1, trial-subtracts the divisor, and sets the quotient bit if the difference is non-negative (33-bit compare). Counter=31 → FIX.
- FIX: apply two's-complement negation per the latched sign, select the word by `m_sel[0]`, register `result` → DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unless a new start is accepted.
- `flush` has priority over everything except `rst`. Any non-IDLE state goes to IDLE next cycle with no `done`; `result` is unchanged. `flush` and `start` in the same cycle → no accept.
- `rst` mid-operation: immediate asynchronous return to reset values.

## Timing

- `stall` = (state ∈ {MUL, DIV, FIX}) | (accept & not special case). It is high in the accept cycle and low in the DONE cycle.
- `busy` is registered: high from the cycle after accept through FIX.
- Latency, with the accept cycle = 0 and `done` high in cycle N:
  - divide, normal: N=34 (1 load, 32 iterations, 1 FIX);
  - divide special cases: N=1;
  - multiply with `RV32IM_FAST_MUL_EN`: N=1;
  - multiply without it: N=34.
- Back-to-back: a start accepted in the DONE cycle begins the next operation with no idle gap.

## Configuration

- `RV32IM_FAST_MUL_EN` defined: a single-cycle 33x33 signed multiply. Operands are sign- or zero-extended per `sn`, and the result goes IDLE→DONE. The MUL state is unused.
- Not defined: iterative shift-add on absolute values in the MUL state (32 iterations, 64-bit accumulator), then sign fix in FIX, giving N=34. Results must be bit-identical in both builds.

## Structure

- Shared package `rv32im_pkg`:
  - state enum;
  - `sn` encodings (SN_SS=2'b11, SN_SU=2'b10, SN_UU=2'b00);
  - constants DIV0_QUOT=32'hFFFFFFFF and OVF_QUOT=32'h80000000;
  - iteration count 32.
- One sub-module, `rv32im_div_step`: a combinational single restoring-division step (shift, 33-bit subtract, quotient bit).

## Test plan

- MUL 7 × 0xFFFFFFFD, `sn`=11, `m_sel`[0]=0 → `result`=0xFFFFFFEB; `done` at N=1 with the macro, N=34 without.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF, `m_sel`[0]=1 → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFEC (−20) / 3 → 0xFFFFFFFA at N=34, with `stall` high in cycles 0–33. REM of the same operands → 0xFFFFFFFE.
- DIVU 100 / 0 → 0xFFFFFFFF and REMU 100 / 0 → 100, both at N=1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- `flush` in cycle 10 of a DIV → `busy`=0 in cycle 11, no `done` pulse, `result` unchanged. A following DIVU 9/2 → 4 at N=34.
- `rst` asserted in cycle 5 of a DIV → all outputs 0 immediately. Back-to-back start in the DONE cycle → second `done` 34 cycles later. Start with `mul_en`=`div_en`=1 → ignored, `busy` stays 0.
